mul_sequencer: RTL and testbench

- Control FSM for the shift-and-add multiplier datapath (`ALU_mul_module`). It generates every control strobe that datapath consumes and sequences a 16-step unsigned multiply.
- Sits between the microcontroller/instruction decoder and the datapath. The decoder issues `start`. This block drives the A/Q register strobes, the mux/AND selects and `ALS_mul`. It then returns `done`.
- The result is placed on the S-bus in two halves: low (Q) first, then high (A).

---
 rtl/mul_pkg.sv | 37 +++
 rtl/mul_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mul_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
//   - mul_state_e : FSM state encoding (IDLE=0 ... OUT_HI=6)
//   - mul_ctrl_t  : bundle of registered control outputs
//   - MUL_N_ITER  : default number of add/shift iterations
package mul_pkg;

    localparam int unsigned MUL_N_ITER = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClr   = 3'd1,
        StLoadq = 3'd2,
        StAdd   = 3'd3,
        StShift = 3'd4,
        StOutLo = 3'd5,
        StOutHi = 3'd6
    } mul_state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic res_hi;
        logic and1_sw;
        logic and2_sw;
        logic mux1_sw;
        logic mux2_sw;
        logic x_in;
        logic a_rw;
        logic a_clk;
        logic a_clr;
        logic q_rw;
        logic q_clk;
        logic q_clr;
        logic als_mul;
    } mul_ctrl_t;

endpackage

// File: rtl/mul_sequencer.sv
// Control FSM for the shift-and-add multiplier datapath. Sequences an unsigned
// N_ITER-step multiply and presents the result on the S-bus, low half then high half.
//
// Optional feature macro: MUL_ABORT_EN (adds the 'abort' input).
//
// Ports:
//   CLK, CLR_n           clock, asynchronous active-low reset
//   start                operation request, sampled only in IDLE
//   q0_in, carry_in      Q LSB (next-value lookahead) and adder carry-out from datapath
//   abort                (MUL_ABORT_EN only) cancel the running operation
//   busy, done, res_hi   status and S-bus half select
//   AND1_sw .. MUX2_sw   datapath selects
//   x_in, u_in           shift-in bits for A MSB / Q MSB
//   A_*, Q_*             register strobes
//   ALS_mul              S-bus drive enable
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned N_ITER = MUL_N_ITER,
    parameter int unsigned CNT_W  = 5
) (
    input  logic CLK,
    input  logic CLR_n,
    input  logic start,
    input  logic q0_in,
    input  logic carry_in,
`ifdef MUL_ABORT_EN
    input  logic abort,
`endif
    output logic busy,
    output logic done,
    output logic res_hi,
    output logic AND1_sw,
    output logic AND2_sw,
    output logic MUX1_sw,
    output logic MUX2_sw,
    output logic x_in,
    output logic u_in,
    output logic A_RW,
    output logic A_CLK,
    output logic A_CLR,
    output logic Q_RW,
    output logic Q_CLK,
    output logic Q_CLR,
    output logic ALS_mul
);

    mul_state_e       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_add_en, w_add_en_d;
    logic             r_carry, w_carry_d;
    logic             w_abort_hit;
    mul_ctrl_t        r_ctrl;

    // Outputs are decoded from the state being entered so they are registered
    // alongside it; add_en and carry are likewise the values being captured.
    function automatic mul_ctrl_t decode_ctrl(input mul_state_e st, input logic add_en,
                                              input logic carry);
        mul_ctrl_t c;
        c = '0;
        c.busy = (st != StIdle);
        unique case (st)
            StIdle: ;
            StClr: begin
                c.a_clr = 1'b1;
                c.q_clr = 1'b1;
            end
            StLoadq: begin
                c.and2_sw = 1'b1;
                c.q_rw    = 1'b1;
                c.q_clk   = 1'b1;
            end
            StAdd: begin
                c.and1_sw = add_en;
                c.a_rw    = add_en;
                c.a_clk   = add_en;
            end
            StShift: begin
                c.mux1_sw = 1'b1;
                c.mux2_sw = 1'b1;
                c.a_clk   = 1'b1;
                c.q_clk   = 1'b1;
                c.x_in    = carry;
            end
            StOutLo: c.als_mul = 1'b1;
            StOutHi: begin
                c.als_mul = 1'b1;
                c.res_hi  = 1'b1;
                c.done    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_add_en_d  = r_add_en;
        w_carry_d   = r_carry;
        w_abort_hit = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StClr;
                    w_cnt_d   = '0;
                end
            end
            StClr:   w_state_d = StLoadq;
            StLoadq: begin
                // q0_in shows the LSB of the value being loaded this cycle
                w_state_d  = StAdd;
                w_add_en_d = q0_in;
            end
            StAdd: begin
                w_state_d = StShift;
                w_carry_d = r_add_en ? carry_in : 1'b0;
            end
            StShift: begin
                // q0_in shows the post-shift LSB, which steers the next ADD
                w_cnt_d    = r_cnt + 1'b1;
                w_add_en_d = q0_in;
                w_state_d  = (r_cnt == CNT_W'(N_ITER - 1)) ? StOutLo : StAdd;
            end
            StOutLo: w_state_d = StOutHi;
            StOutHi: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
`ifdef MUL_ABORT_EN
        if (abort && (r_state != StIdle)) begin
            w_abort_hit = 1'b1;
            w_state_d   = StIdle;
        end
`endif
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_add_en <= 1'b0;
            r_carry  <= 1'b0;
            r_ctrl   <= '0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_add_en <= w_add_en_d;
            r_carry  <= w_carry_d;
            r_ctrl   <= decode_ctrl(w_state_d, w_add_en_d, w_carry_d);
        end
    end

    assign busy    = r_ctrl.busy;
    assign done    = r_ctrl.done;
    assign res_hi  = r_ctrl.res_hi;
    assign AND1_sw = r_ctrl.and1_sw;
    assign AND2_sw = r_ctrl.and2_sw;
    assign MUX1_sw = r_ctrl.mux1_sw;
    assign MUX2_sw = r_ctrl.mux2_sw;
    assign x_in    = r_ctrl.x_in;
    assign u_in    = 1'b0;
    assign A_RW    = r_ctrl.a_rw;
    assign A_CLK   = r_ctrl.a_clk;
    assign Q_RW    = r_ctrl.q_rw;
    assign Q_CLK   = r_ctrl.q_clk;
    assign ALS_mul = r_ctrl.als_mul;
`ifdef MUL_ABORT_EN
    // Abort clears the datapath in the abort cycle itself, ahead of the return to IDLE.
    assign A_CLR = r_ctrl.a_clr | w_abort_hit;
    assign Q_CLR = r_ctrl.q_clr | w_abort_hit;
`else
    assign A_CLR = r_ctrl.a_clr;
    assign Q_CLR = r_ctrl.q_clr;
`endif

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

    logic CLK = 1'b0;
    logic CLR_n = 1'b0;
    logic start = 1'b0;
    logic q0_in, carry_in;
`ifdef MUL_ABORT_EN
    logic abort = 1'b0;
`endif
    logic busy, done, res_hi, AND1_sw, AND2_sw, MUX1_sw, MUX2_sw, x_in, u_in;
    logic A_RW, A_CLK, A_CLR, Q_RW, Q_CLK, Q_CLR, ALS_mul;

    int n_checks = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mul_sequencer dut (
        .CLK      (CLK),
        .CLR_n    (CLR_n),
        .start    (start),
        .q0_in    (q0_in),
        .carry_in (carry_in),
`ifdef MUL_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .res_hi   (res_hi),
        .AND1_sw  (AND1_sw),
        .AND2_sw  (AND2_sw),
        .MUX1_sw  (MUX1_sw),
        .MUX2_sw  (MUX2_sw),
        .x_in     (x_in),
        .u_in     (u_in),
        .A_RW     (A_RW),
        .A_CLK    (A_CLK),
        .A_CLR    (A_CLR),
        .Q_RW     (Q_RW),
        .Q_CLK    (Q_CLK),
        .Q_CLR    (Q_CLR),
        .ALS_mul  (ALS_mul)
    );

    // Datapath model: A/Q registers driven by the sequencer's strobes.
    logic [15:0] dp_a = '0;
    logic [15:0] dp_q = '0;
    logic [15:0] mcand = '0;
    logic [15:0] mplier = '0;
    logic [15:0] a_bus, s_bus;
    logic [16:0] sum17;
    logic        is_load, is_add, is_shift;

    always_comb begin
        is_load  = Q_CLK && Q_RW && AND2_sw;
        is_add   = A_CLK && A_RW && AND1_sw;
        is_shift = MUX1_sw && MUX2_sw && A_CLK && Q_CLK;
        a_bus    = is_load ? mplier : mcand;
        sum17    = {1'b0, dp_a} + {1'b0, a_bus};
        carry_in = sum17[16];
        q0_in    = is_load ? a_bus[0] : (is_shift ? dp_q[1] : dp_q[0]);
        s_bus    = res_hi ? dp_a : dp_q;
    end

    always @(posedge CLK) begin
        if (A_CLR) dp_a <= '0;
        else if (is_shift) dp_a <= {x_in, dp_a[15:1]};
        else if (is_add) dp_a <= sum17[15:0];
        if (Q_CLR) dp_q <= '0;
        else if (is_shift) dp_q <= {dp_a[0], dp_q[15:1]};
        else if (is_load) dp_q <= a_bus;
    end

    function automatic logic [15:0] all_outs();
        return {busy, done, res_hi, AND1_sw, AND2_sw, MUX1_sw, MUX2_sw, x_in, u_in,
                A_RW, A_CLK, A_CLR, Q_RW, Q_CLK, Q_CLR, ALS_mul};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete operation: start sampled at edge k; cycle k+n is observed at the
    // n-th following negedge. Optionally pulses start again at cycle k+stray.
    task automatic run_op(input string tag, input logic [15:0] mc, input logic [15:0] mp,
                          input int stray);
        logic [31:0] product;
        logic [15:0] lo, hi;
        int done_cyc, done_cnt, busy_cnt, a_clk_cnt, q_clk_cnt, add_cnt, shf_cnt, u_cnt;
        product = {16'h0, mc} * {16'h0, mp};
        lo = 16'hdead; hi = 16'hdead;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; a_clk_cnt = 0; q_clk_cnt = 0;
        add_cnt = 0; shf_cnt = 0; u_cnt = 0;
        mcand = mc; mplier = mp;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = n; end
            if (ALS_mul && !res_hi) lo = s_bus;
            if (ALS_mul && res_hi) hi = s_bus;
            if (A_CLK) a_clk_cnt++;
            if (Q_CLK) q_clk_cnt++;
            if (A_RW) add_cnt++;
            if (MUX1_sw) shf_cnt++;
            if (u_in) u_cnt++;
            start = (stray > 0 && n == stray);
            @(negedge CLK);
        end
        start = 1'b0;
        check_eq({tag, " lo"}, {16'h0, lo}, {16'h0, product[15:0]});
        check_eq({tag, " hi"}, {16'h0, hi}, {16'h0, product[31:16]});
        check_eq({tag, " done_cycle"}, done_cyc, 36);
        check_eq({tag, " done_count"}, done_cnt, 1);
        check_eq({tag, " busy_cycles"}, busy_cnt, 36);
        check_eq({tag, " add_strobes"}, add_cnt, $countones(mp));
        check_eq({tag, " shift_strobes"}, shf_cnt, 16);
        check_eq({tag, " a_clk_pulses"}, a_clk_cnt, 16 + $countones(mp));
        check_eq({tag, " q_clk_pulses"}, q_clk_cnt, 17);
        check_eq({tag, " u_in_high"}, u_cnt, 0);
    endtask

    initial begin
        #23;
        check_eq("reset outputs", {16'h0, all_outs()}, 32'h0);
        @(negedge CLK); CLR_n = 1'b1;
        @(negedge CLK);
        check_eq("idle outputs", {16'h0, all_outs()}, 32'h0);

        run_op("5x3", 16'h0003, 16'h0005, 0);
        run_op("ffff", 16'hFFFF, 16'hFFFF, 0);
        run_op("zero_mplier", 16'h1234, 16'h0000, 0);
        run_op("stray_start", 16'h00A5, 16'h0101, 10);
        for (int i = 0; i < 6; i++) begin
            run_op("random", 16'($urandom), 16'($urandom), 0);
        end

        // Asynchronous reset in the middle of an operation
        mcand = 16'h0007; mplier = 16'h0009;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (19) @(negedge CLK);
        check_eq("busy before reset", {31'h0, busy}, 32'h1);
        CLR_n = 1'b0;
        #1;
        check_eq("mid-op reset outputs", {16'h0, all_outs()}, 32'h0);
        @(negedge CLK);
        check_eq("held reset outputs", {16'h0, all_outs()}, 32'h0);
        CLR_n = 1'b1;
        run_op("after_reset", 16'h0003, 16'h0005, 0);

`ifdef MUL_ABORT_EN
        begin
            int bad;
            bad = 0;
            mcand = 16'h0003; mplier = 16'h0005;
            @(negedge CLK); start = 1'b1;
            @(negedge CLK); start = 1'b0;
            repeat (11) @(negedge CLK);
            abort = 1'b1;
            #1;
            check_eq("abort clear", {30'h0, A_CLR, Q_CLR}, 32'h3);
            @(negedge CLK); abort = 1'b0;
            check_eq("abort idle", {16'h0, all_outs()}, 32'h0);
            repeat (40) begin
                if (done || ALS_mul || busy) bad++;
                @(negedge CLK);
            end
            check_eq("abort no done", bad, 0);
            run_op("after_abort", 16'h0003, 16'h0005, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
